// File: rtl/cl_pairhmm_compute_arbiter_pkg.sv
// Engine request/result types shared with the PairHMM datapath, plus the
// arbiter-local tag type and round-robin wrap helper.
package PairHMMPackage;

  localparam int ARB_MAX_WORKERS     = 16;
  localparam int ARB_WORKER_ID_WIDTH = 4;

  typedef struct packed {
    logic [15:0] read_id;
    logic [15:0] read_len;
    logic [15:0] hap_len;
    logic [15:0] flags;
  } request_t;

  typedef struct packed {
    logic [15:0] read_id;
    logic [31:0] score;
  } result_t;

endpackage

package cl_pairhmm_compute_arbiter_pkg;

  import PairHMMPackage::*;

  typedef logic [ARB_WORKER_ID_WIDTH-1:0] tag_t;

  // (base + step) mod n, valid for base < n and step < n
  function automatic tag_t wrap_add(tag_t base, int unsigned step, int unsigned n);
    int unsigned s;
    s = 32'(base) + step;
    if (s >= n) s = s - n;
    return tag_t'(s);
  endfunction

endpackage

// File: rtl/cl_pairhmm_compute_arbiter_if.sv
// Worker, engine and status signals of the compute arbiter.
// master: workers/engine side; slave: the arbiter.
interface cl_pairhmm_compute_arbiter_if
  import PairHMMPackage::*;
#(
  parameter int NUM_WORKERS     = 4,
  parameter int MAX_OUTSTANDING = 32
) ();

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_WORKERS-1:0]     req_valid_i;
  request_t [NUM_WORKERS-1:0] req_data_i;
  logic [NUM_WORKERS-1:0]     req_ready_o;

  logic     eng_req_write_o;
  request_t eng_req_data_o;
  logic     eng_req_full_i;

  logic    eng_res_read_o;
  result_t eng_res_data_i;
  logic    eng_res_empty_i;

  logic [NUM_WORKERS-1:0] res_write_o;
  result_t                res_data_o;
  logic [NUM_WORKERS-1:0] res_full_i;

  logic [OUT_W-1:0] outstanding_o;
  logic             idle_o;
  logic             protocol_error_o;

  modport master (
    output req_valid_i, req_data_i, eng_req_full_i, eng_res_data_i,
           eng_res_empty_i, res_full_i,
    input  req_ready_o, eng_req_write_o, eng_req_data_o, eng_res_read_o,
           res_write_o, res_data_o, outstanding_o, idle_o, protocol_error_o
  );

  modport slave (
    input  req_valid_i, req_data_i, eng_req_full_i, eng_res_data_i,
           eng_res_empty_i, res_full_i,
    output req_ready_o, eng_req_write_o, eng_req_data_o, eng_res_read_o,
           res_write_o, res_data_o, outstanding_o, idle_o, protocol_error_o
  );

endinterface

// File: rtl/cl_pairhmm_tag_fifo.sv
// First-word-fall-through FIFO holding the owner tag of each in-flight request.
// DEPTH must be a power of two so the pointers wrap on their own.
module cl_pairhmm_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // storage needs no reset: empty/count gate every use of it
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/cl_pairhmm_compute_arbiter.sv
// Round-robin arbiter sharing one in-order PairHMM engine among NUM_WORKERS
// cores; a tag FIFO routes each engine result back to the worker that issued it.
module cl_pairhmm_compute_arbiter
  import PairHMMPackage::*;
  import cl_pairhmm_compute_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS     = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int DEBUG_VERBOSITY = 0
) (
  input logic                         clock_i,
  input logic                         reset_i,
  cl_pairhmm_compute_arbiter_if.slave bus
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  tag_t             rr_ptr;
  tag_t             grant_idx;
  logic             grant_found;
  logic             issue;
  tag_t             head_tag;
  logic             head_full;
  logic             ret;
  logic             tag_empty;
  logic             tag_full;
  logic [OUT_W-1:0] tag_count;
  logic             proto_err;

  // first valid worker at or after rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      for (int k = 0; k < NUM_WORKERS; k++) begin
        if (!grant_found && bus.req_valid_i[k] &&
            wrap_add(rr_ptr, i, NUM_WORKERS) == tag_t'(k)) begin
          grant_found = 1'b1;
          grant_idx   = tag_t'(k);
        end
      end
    end
  end

  // tag_full is registered, so a pop this cycle only frees a slot next cycle
  assign issue = reset_i && grant_found && !bus.eng_req_full_i && !tag_full;

  always_comb begin
    bus.req_ready_o    = '0;
    bus.eng_req_data_o = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (grant_idx == tag_t'(k)) begin
        bus.req_ready_o[k] = issue;
        bus.eng_req_data_o = bus.req_data_i[k];
      end
    end
  end

  assign bus.eng_req_write_o = issue;

  always_comb begin
    head_full = 1'b0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (head_tag == tag_t'(k)) head_full = bus.res_full_i[k];
    end
  end

  // a full head worker stalls every return behind it
  assign ret = reset_i && !bus.eng_res_empty_i && !tag_empty && !head_full;

  always_comb begin
    bus.res_write_o = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (head_tag == tag_t'(k)) bus.res_write_o[k] = ret;
    end
  end

  assign bus.eng_res_read_o   = ret;
  assign bus.res_data_o       = bus.eng_res_data_i;
  assign bus.outstanding_o    = tag_count;
  assign bus.idle_o           = (tag_count == '0) && !(|bus.req_valid_i);
  assign bus.protocol_error_o = proto_err;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (issue) rr_ptr <= wrap_add(grant_idx, 1, NUM_WORKERS);
      if (!bus.eng_res_empty_i && tag_empty) proto_err <= 1'b1;
    end
  end

  cl_pairhmm_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ARB_WORKER_ID_WIDTH)
  ) u_tag_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (issue),
    .pop       (ret),
    .push_data (grant_idx),
    .pop_data  (head_tag),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // with verbosity enabled, strobes are checked to be one-hot in simulation
  if (DEBUG_VERBOSITY >= 1) begin : g_debug
    always @(posedge clock_i) begin
      if (reset_i) begin
        assert ($onehot0(bus.req_ready_o));
        assert ($onehot0(bus.res_write_o));
      end
    end
  end

endmodule

// File: doc/cl_pairhmm_compute_arbiter.md
CL_PAIRHMM_COMPUTE_ARBITER -- requirements
Module: cl_pairhmm_compute_arbiter

Interface
REQ-001 Parameter NUM_WORKERS, default 4: number of worker cores sharing one compute engine; range 2..16.
REQ-002 Parameter MAX_OUTSTANDING, default 32: tag FIFO depth, power of 2; caps requests in flight.
REQ-003 Parameter DEBUG_VERBOSITY, default 0: simulation-only $display level.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clock_i  in  1  single clock.
REQ-006 reset_i  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i  in  NUM_WORKERS  worker k has a request_t pending.
REQ-008 req_data_i  in  NUM_WORKERS x request_t  per-worker request.
REQ-009 req_ready_o  out  NUM_WORKERS  one-hot accept strobe.
REQ-010 eng_req_write_o / eng_req_data_o / eng_req_full_i  out/out/in  1/request_t/1  engine request FIFO.
REQ-011 eng_res_read_o / eng_res_data_i / eng_res_empty_i  out/in/in  1/result_t/1  engine result FIFO, first-word-fall-through.
REQ-012 res_write_o  out  NUM_WORKERS  one-hot result strobe; res_data_o  out  result_t  shared result data.
REQ-013 res_full_i  in  NUM_WORKERS  worker k result FIFO full.
REQ-014 outstanding_o  out  clog2(MAX_OUTSTANDING)+1  requests in flight; idle_o  out  1; protocol_error_o  out  1  sticky.

Function
REQ-015 Issue condition: some req_valid_i set, !eng_req_full_i, outstanding < MAX_OUTSTANDING.
REQ-016 When issuing, grant the first valid worker at or after rr_ptr, modulo NUM_WORKERS. Drive req_ready_o[k], eng_req_write_o and eng_req_data_o = req_data_i[k] combinationally in the same cycle.
REQ-017 At most one grant per cycle. After a grant to k, rr_ptr <= (k+1) mod NUM_WORKERS, wrapping from NUM_WORKERS-1 to 0. Without a grant, rr_ptr holds.
REQ-018 Each issue pushes k into the tag FIFO. The engine is in-order, so the tag FIFO head names the owner of the next result.
REQ-019 Return condition: !eng_res_empty_i, tag FIFO not empty, !res_full_i[head]. When it holds:
- assert eng_res_read_o and res_write_o[head];
- res_data_o = eng_res_data_i;
- pop the tag.
Latency is 0 cycles.
REQ-020 Head-of-line blocking is intended: a full head worker stalls all returns. Nothing is dropped or reordered.
REQ-021 Push and pop in the same cycle leave outstanding unchanged.
REQ-022 At outstanding = MAX_OUTSTANDING, no issue occurs. A pop in that cycle permits an issue in the next cycle, not the current one.
REQ-023 If !eng_res_empty_i while the tag FIFO is empty: set protocol_error_o until reset and keep eng_res_read_o low.
REQ-024 res_write_o and req_ready_o SHALL be zero whenever their conditions are false. res_data_o is don't-care when res_write_o = 0.
REQ-025 idle_o = (outstanding = 0) and no req_valid_i set.
REQ-026 DEBUG_VERBOSITY >= 1 prints each grant and each return with the worker index.

Reset
REQ-027 While reset_i = 0:
- rr_ptr = 0, tag FIFO empty, outstanding_o = 0, protocol_error_o = 0;
- all strobes (req_ready_o, eng_req_write_o, eng_res_read_o, res_write_o) = 0;
- idle_o follows REQ-025.
REQ-028 Reset mid-operation discards in-flight tags. The engine and its FIFOs are reset by the same reset_i. Results arriving after reset fall under REQ-023.

Structure
REQ-029 request_t and result_t come from PairHMMPackage. Add ARB_MAX_WORKERS = 16 and ARB_WORKER_ID_WIDTH = 4 there. Tags are ARB_WORKER_ID_WIDTH wide.
REQ-030 The tag FIFO SHALL be sub-module cl_pairhmm_tag_fifo:
- parameters DEPTH and WIDTH;
- ports push, pop, data in/out, count, empty, full;
- FWFT output, simultaneous push/pop allowed.

Verification
REQ-031 NUM_WORKERS=4, all valid every cycle, engine never full -> grants 0,1,2,3,0,... one per cycle, and each worker receives results in its own issue order.
REQ-032 Only worker 2 valid after a grant to 3 -> grant goes to 2. rr_ptr wraps 3->0 and then advances to 3.
REQ-033 MAX_OUTSTANDING=4, engine returns nothing -> exactly 4 issues, outstanding_o = 4, and req_ready_o stays 0 thereafter.
REQ-034 Head tag = 1 with res_full_i[1] = 1 for 10 cycles and a result pending -> eng_res_read_o = 0 for 10 cycles, then one return to worker 1.
REQ-035 Issue and return in the same cycle at outstanding = 3 -> outstanding_o stays 3.
REQ-036 Inject a result with the tag FIFO empty -> protocol_error_o = 1 and stays 1. Drive reset_i = 0 mid-stream -> all outputs take reset values at once.
